// File: rtl/fp_add_wb_pkg.sv
// Shared FP definitions for the adder writeback path: exception-flag bit layout and packing helper.
// Flag vector order is {inv, ov, un, inexact}, matching the CSR fflags field.
package fp_add_wb_pkg;

  localparam int FLG_W   = 4;
  localparam int FLG_INV = 3;
  localparam int FLG_OV  = 2;
  localparam int FLG_UN  = 1;
  localparam int FLG_NX  = 0;

  function automatic logic [FLG_W-1:0] pack_flags(input logic inv, input logic ov,
                                                  input logic un, input logic nx);
    logic [FLG_W-1:0] f;
    f          = '0;
    f[FLG_INV] = inv;
    f[FLG_OV]  = ov;
    f[FLG_UN]  = un;
    f[FLG_NX]  = nx;
    return f;
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Circular result FIFO with registered head, flush and count; a push lands one cycle later (no fall-through).
// Push and pop in the same cycle both take effect, including when full; head reads as zero when empty.
module fp_res_fifo
#(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [PTRW:0] o_count
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [PTRW:0]   r_cnt;
  logic [W-1:0]    r_dout;
  logic [PTRW-1:0] w_rptr_nxt;
  logic [PTRW:0]   w_cnt_nxt;
  logic            w_push;
  logic            w_pop;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == (PTRW+1)'(DEPTH));
  assign w_pop      = i_pop & ~o_empty;
  assign w_push     = i_push & (~o_full | w_pop);
  assign w_rptr_nxt = r_rptr + PTRW'(w_pop);
  assign w_cnt_nxt  = r_cnt + (PTRW+1)'(w_push) - (PTRW+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Head register tracks the entry at the next read pointer; when that slot is being
  // written this same edge, the incoming data is forwarded instead of the stale memory word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTRW'(1);
      end
      r_rptr <= w_rptr_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_cnt_nxt == '0) begin
        r_dout <= '0;
      end else if (w_push && (r_wptr == w_rptr_nxt)) begin
        r_dout <= i_din;
      end else begin
        r_dout <= r_mem[w_rptr_nxt];
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_count = r_cnt;

endmodule

// File: rtl/fp_add_wb.sv
// Writeback stage behind the fixed-latency FP adder: tracks issues, queues results, accumulates sticky fflags.
// Issue-to-res_valid is 3 cycles; issue_ready is a credit check over queued plus in-flight ops, so nothing is lost.
module fp_add_wb
  import fp_add_wb_pkg::*;
#(
  parameter int W     = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [W-1:0]     add_out,
  input  logic             add_ov,
  input  logic             add_un,
  input  logic             add_inv,
  input  logic             add_inexact,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [FLG_W-1:0] res_flags,
  output logic [FLG_W-1:0] fflags,
  input  logic             fflags_clr,
  input  logic             flush,
  output logic             busy
);

  localparam logic [PTRW:0] L_DEPTH = (PTRW+1)'(DEPTH);

  logic [LAT-1:0]     r_vp;
  logic [FLG_W-1:0]   r_fflags;
  logic               w_acc;
  logic               w_cap;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [PTRW:0]      w_cnt;
  logic [PTRW:0]      w_occ;
  logic [FLG_W-1:0]   w_cap_flags;
  logic [W+FLG_W-1:0] w_head;

  assign w_cap       = r_vp[LAT-1];
  assign w_cap_flags = pack_flags(add_inv, add_ov, add_un, add_inexact);
  assign w_pop       = res_valid & res_ready;

  // Credits: every in-flight op already owns a FIFO slot.
  always_comb begin
    w_occ = w_cnt;
    for (int k = 0; k < LAT; k++) begin
      w_occ = w_occ + (PTRW+1)'(r_vp[k]);
    end
  end

  assign issue_ready = (w_occ < L_DEPTH) & ~flush;
  assign w_acc       = issue_valid & issue_ready;
  assign w_push      = w_cap & ~flush & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vp <= '0;
    end else if (flush) begin
      r_vp <= '0;
    end else begin
      r_vp[0] <= w_acc;
      for (int k = 1; k < LAT; k++) begin
        r_vp[k] <= r_vp[k-1];
      end
    end
  end

  // A capture dropped by flush contributes no flags; a clear is still honoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fflags <= '0;
    end else if (w_cap && !flush) begin
      r_fflags <= (fflags_clr ? '0 : r_fflags) | w_cap_flags;
    end else if (fflags_clr) begin
      r_fflags <= '0;
    end
  end

  fp_res_fifo #(
    .W     (W + FLG_W),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_din   ({add_out, w_cap_flags}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign res_valid = ~w_empty;
  assign res_data  = w_head[W+FLG_W-1:FLG_W];
  assign res_flags = w_head[FLG_W-1:0];
  assign fflags    = r_fflags;
  assign busy      = (|r_vp) | res_valid;

endmodule

// File: tb/tb_fp_add_wb.sv
// Bench for fp_add_wb: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fp_add_wb;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] add_out;
  logic        add_ov;
  logic        add_un;
  logic        add_inv;
  logic        add_inexact;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic [3:0]  fflags;
  logic        fflags_clr;
  logic        flush;
  logic        busy;

  fp_add_wb dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .add_out     (add_out),
    .add_ov      (add_ov),
    .add_un      (add_un),
    .add_inv     (add_inv),
    .add_inexact (add_inexact),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .flush       (flush),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; optionally scramble the adder outputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_en) begin
      add_out = $urandom;
      {add_inv, add_ov, add_un, add_inexact} = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic zero_adder();
    add_out = '0;
    {add_inv, add_ov, add_un, add_inexact} = 4'b0000;
  endtask

  // Reference model: results queue, capture-cycle list of in-flight ops, sticky flags.
  logic [35:0] expq[$];
  int          pendq[$];
  logic [3:0]  m_ff = '0;
  int          t = 0;

  initial begin
    logic        m_valid;
    logic [35:0] m_head;
    logic        m_ready;
    logic        cap_now;
    logic [3:0]  cflags;
    int          m_occ;
    forever begin
      @(negedge clk);
      if (!rst) begin
        expq.delete();
        pendq.delete();
        m_ff = '0;
      end
      m_valid = (expq.size() != 0);
      m_head  = m_valid ? expq[0] : 36'h0;
      m_occ   = expq.size() + pendq.size();
      m_ready = (m_occ < DEPTH) && !flush;
      chk("res_valid", 64'(res_valid), 64'(m_valid));
      chk("res_data", 64'(res_data), 64'(m_head[35:4]));
      chk("res_flags", 64'(res_flags), 64'(m_head[3:0]));
      chk("fflags", 64'(fflags), 64'(m_ff));
      chk("issue_ready", 64'(issue_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'((pendq.size() != 0) || m_valid));
      if (rst) begin
        checks++;
        if (dut.w_cap && !flush && dut.w_full && !dut.w_pop) begin
          errors++;
          $display("FAIL fifo_overflow: capture with full FIFO and no pop (t=%0t)", $time);
        end
        chk("fifo_count_bound", 64'(dut.u_fifo.o_count <= 3'(DEPTH)), 64'(1));
        cap_now = (pendq.size() != 0) && (pendq[0] == t);
        cflags  = {add_inv, add_ov, add_un, add_inexact};
        if (flush) begin
          expq.delete();
          pendq.delete();
          if (fflags_clr) m_ff = '0;
        end else begin
          if (m_valid && res_ready) void'(expq.pop_front());
          if (cap_now) begin
            void'(pendq.pop_front());
            expq.push_back({add_out, cflags});
            m_ff = (fflags_clr ? 4'b0000 : m_ff) | cflags;
          end else if (fflags_clr) begin
            m_ff = '0;
          end
          if (issue_valid && m_ready) pendq.push_back(t + LAT);
        end
      end
      t++;
    end
  end

  initial begin
    int n_acc;
    rst = 1'b0;
    issue_valid = 1'b0;
    res_ready = 1'b1;
    fflags_clr = 1'b0;
    flush = 1'b0;
    zero_adder();

    // Reset values
    repeat (2) cyc();
    #2;
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_fflags", 64'(fflags), 64'(0));
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    cyc();
    rst = 1'b1;

    // Single op: issue cycle 0, result on adder in cycle 2, visible cycle 3
    issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    cyc();
    add_out = 32'h4040_0000;
    add_inexact = 1'b1;
    #2;
    chk("single_not_early", 64'(res_valid), 64'(0));
    cyc();
    zero_adder();
    #2;
    chk("single_valid", 64'(res_valid), 64'(1));
    chk("single_data", 64'(res_data), 64'h4040_0000);
    chk("single_flags", 64'(res_flags), 64'(4'b0001));
    chk("single_fflags", 64'(fflags), 64'(4'b0001));
    cyc();

    // Backpressure: exactly DEPTH accepts, then stall; release and stream 20 ops
    rnd_en = 1'b1;
    res_ready = 1'b0;
    issue_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (issue_ready) n_acc++;
      cyc();
    end
    chk("bp_accepts", 64'(n_acc), 64'(4));
    #2;
    chk("bp_stalled", 64'(issue_ready), 64'(0));
    chk("bp_full_valid", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("stream_ready", 64'(issue_ready), 64'(1));
      chk("stream_valid", 64'(res_valid), 64'(1));
      cyc();
    end
    issue_valid = 1'b0;
    repeat (6) cyc();

    // Sticky flags
    rnd_en = 1'b0;
    zero_adder();
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    issue_valid = 1'b1;
    cyc();
    cyc();
    issue_valid = 1'b0;
    add_inv = 1'b1;
    cyc();
    add_inv = 1'b0;
    add_ov = 1'b1;
    cyc();
    add_ov = 1'b0;
    #2;
    chk("sticky_inv_ov", 64'(fflags), 64'(4'b1100));
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    #2;
    chk("sticky_clear", 64'(fflags), 64'(4'b0000));
    issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    cyc();
    add_un = 1'b1;
    fflags_clr = 1'b1;
    cyc();
    add_un = 1'b0;
    fflags_clr = 1'b0;
    #2;
    chk("sticky_clr_cap", 64'(fflags), 64'(4'b0010));
    repeat (3) cyc();

    // Flush with 2 queued and 2 in flight; the capture in the flush cycle carries inv
    res_ready = 1'b0;
    issue_valid = 1'b1;
    cyc();
    cyc();
    issue_valid = 1'b0;
    repeat (3) cyc();
    issue_valid = 1'b1;
    cyc();
    cyc();
    flush = 1'b1;
    add_inv = 1'b1;
    #2;
    chk("flush_queued", 64'(res_valid), 64'(1));
    chk("flush_ready_low", 64'(issue_ready), 64'(0));
    cyc();
    flush = 1'b0;
    issue_valid = 1'b0;
    add_inv = 1'b0;
    #2;
    chk("flush_valid", 64'(res_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_fflags", 64'(fflags), 64'(4'b0010));
    chk("flush_ready", 64'(issue_ready), 64'(1));
    cyc();
    res_ready = 1'b1;

    // Asynchronous reset with 3 ops outstanding
    rnd_en = 1'b1;
    res_ready = 1'b0;
    issue_valid = 1'b1;
    repeat (3) cyc();
    issue_valid = 1'b0;
    chk("arst_pre_valid", 64'(res_valid), 64'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(res_valid), 64'(0));
    chk("arst_data", 64'(res_data), 64'(0));
    chk("arst_flags", 64'(res_flags), 64'(0));
    chk("arst_fflags", 64'(fflags), 64'(0));
    chk("arst_ready", 64'(issue_ready), 64'(1));
    chk("arst_busy", 64'(busy), 64'(0));
    cyc();
    rst = 1'b1;
    rnd_en = 1'b0;
    zero_adder();
    res_ready = 1'b1;
    issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    cyc();
    add_out = 32'h3F80_0000;
    add_ov = 1'b1;
    #2;
    chk("post_rst_not_early", 64'(res_valid), 64'(0));
    cyc();
    zero_adder();
    #2;
    chk("post_rst_valid", 64'(res_valid), 64'(1));
    chk("post_rst_data", 64'(res_data), 64'h3F80_0000);
    chk("post_rst_flags", 64'(res_flags), 64'(4'b0100));
    cyc();

    // Random traffic
    rnd_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      res_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      fflags_clr  = ($urandom_range(0, 9) == 0);
      cyc();
    end
    issue_valid = 1'b0;
    flush = 1'b0;
    fflags_clr = 1'b0;
    res_ready = 1'b1;
    repeat (10) cyc();
    #2;
    chk("drain_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
